// File: rtl/mem_store_buffer_pkg.sv
// Shared constants for the post-commit store buffer.
package mem_store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int BYTE_W   = 8;
endpackage

// File: rtl/sb_fwd_merge.sv
// Byte-granular load forwarding from pending store-buffer entries.
module sb_fwd_merge
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0]        addr     [DEPTH],
  input  logic [DATA_W/BYTE_W-1:0] wstrb    [DEPTH],
  input  logic [DATA_W-1:0]        data     [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic [DATA_W/BYTE_W-1:0] fwd_mask,
  output logic [DATA_W-1:0]        fwd_data
);
  localparam int NB = DATA_W / BYTE_W;
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a younger matching lane overrides an older one.
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (addr[idx] == ld_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb[idx][b]) begin
            fwd_mask[b]                      = 1'b1;
            fwd_data[b*BYTE_W +: BYTE_W] = data[idx][b*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end
endmodule

// File: rtl/mem_store_buffer.sv
// Post-commit store buffer: in-order drain to memory, byte-level load
// forwarding, optional coalescing into the youngest non-head entry.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH    = SB_DEPTH,
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter bit COALESCE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W/BYTE_W-1:0]   st_wstrb,
  input  logic [DATA_W-1:0]          st_wdata,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic [DATA_W/BYTE_W-1:0]   fwd_mask,
  output logic [DATA_W-1:0]          fwd_data,
  output logic                       fwd_hit,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W/BYTE_W-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int NB = DATA_W / BYTE_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [NB-1:0]     wstrb_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [PW-1:0]     head, tail, youngest;
  logic [DEPTH-1:0]  valid;
  logic              coal_hit, push, pop;

  assign youngest = tail - PW'(1);

  // count >= 2 keeps the head out of reach, so presented memory data is stable.
  assign coal_hit = COALESCE && (count >= CW'(2)) && (st_wstrb != '0) &&
                    (addr_q[youngest] == st_addr);

  assign st_ready  = (count < FULL) || coal_hit || (st_wstrb == '0);
  assign push      = st_valid && (st_wstrb != '0) && !coal_hit && (count < FULL);
  assign mem_valid = (count != '0);
  assign pop       = mem_valid && mem_ready;
  assign empty     = (count == '0);

  assign mem_addr  = addr_q[head];
  assign mem_wstrb = wstrb_q[head];
  assign mem_wdata = data_q[head];

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++)
      valid[i] = ({1'b0, PW'(i) - head} < count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wstrb_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail]  <= st_addr;
        wstrb_q[tail] <= st_wstrb;
        data_q[tail]  <= st_wdata;
        tail          <= tail + PW'(1);
      end
      if (st_valid && coal_hit) begin
        wstrb_q[youngest] <= wstrb_q[youngest] | st_wstrb;
        for (int b = 0; b < NB; b++)
          if (st_wstrb[b])
            data_q[youngest][b*BYTE_W +: BYTE_W] <= st_wdata[b*BYTE_W +: BYTE_W];
      end
      if (pop)
        head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  sb_fwd_merge #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .addr     (addr_q),
    .wstrb    (wstrb_q),
    .data     (data_q),
    .valid    (valid),
    .head     (head),
    .ld_addr  (ld_addr),
    .fwd_mask (fwd_mask),
    .fwd_data (fwd_data)
  );

  assign fwd_hit = |fwd_mask;
endmodule
